// File: rtl/instr_loader_if.sv
// instr_loader_if: groups the loader's byte-stream handshake and its
// instruction-memory write port.
//   byte_in/byte_valid  stream data and qualifier, driven by the byte source
//   byte_ready          loader can take a byte this cycle
//   mem_we/mem_addr/mem_wdata  one-cycle write strobe, address and word
// Modports: slave = loader side, master = stream source / memory side.
interface instr_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// instr_loader: receives a framed byte stream (LEN_HI, LEN_LO, N x {hi, lo},
// CHK), rejects reserved opcodes, writes words to consecutive instruction
// memory addresses from 0, verifies the trailing XOR checksum and keeps the
// CPU in reset until a load finishes cleanly.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             one-cycle pulse, starts a load from IDLE/DONE/ERR
//   bus (slave)       byte stream handshake + memory write port
//   cpu_hold          high in every state except DONE
//   busy              load in progress (LEN_HI .. CHK)
//   done/err          level status of the last load
//   err_code          01 length, 10 reserved opcode, 11 checksum, 00 none
//   word_count        words written in the current/last load
// ADDR_W must be at most 15 and DEPTH at most 2**ADDR_W.
module instr_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  instr_loader_if.slave     bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_INS_HI,
    ST_INS_LO,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t            state_reg, state_next;
  logic              byte_ready_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [15:0]       mem_wdata_reg;
  logic              cpu_hold_reg, busy_reg, done_reg, err_reg;
  logic [1:0]        err_code_reg;
  logic [ADDR_W:0]   cnt_reg;      // write index; doubles as word_count
  logic [ADDR_W:0]   len_reg;      // N, already known to be <= DEPTH
  logic [7:0]        len_hi_reg;
  logic [7:0]        hi_reg;
  logic [7:0]        xor_reg;

  logic              accept;
  logic              start_load;
  logic [15:0]       len_full;

  assign accept     = bus.byte_valid & byte_ready_reg;
  assign len_full   = {len_hi_reg, bus.byte_in};
  assign start_load = start && (state_reg == ST_IDLE || state_reg == ST_DONE ||
                                state_reg == ST_ERR);

  // Reserved: [15:12] 1001..1101, or [15:10] 111110/111111 (0xF8..0xFF).
  function automatic logic is_reserved(input logic [7:0] hi);
    return ((hi[7:4] >= 4'd9) && (hi[7:4] <= 4'd13)) || (hi[7:3] == 5'b11111);
  endfunction

  function automatic logic takes_bytes(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_INS_HI) ||
           (s == ST_INS_LO) || (s == ST_CHK);
  endfunction

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (accept) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_full} > DEPTH_W) state_next = ST_ERR;
          else if (len_full == 16'd0)     state_next = ST_CHK;
          else                            state_next = ST_INS_HI;
        end
      end
      ST_INS_HI: begin
        if (accept) state_next = is_reserved(bus.byte_in) ? ST_ERR : ST_INS_LO;
      end
      ST_INS_LO: begin
        if (accept) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        state_next = (cnt_reg + 1'b1 == len_reg) ? ST_CHK : ST_INS_HI;
      end
      ST_CHK: begin
        if (accept) state_next = (bus.byte_in == xor_reg) ? ST_DONE : ST_ERR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe without any decode after the flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      byte_ready_reg <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      cpu_hold_reg   <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_code_reg   <= 2'b00;
      cnt_reg        <= '0;
      len_reg        <= '0;
      len_hi_reg     <= '0;
      hi_reg         <= '0;
      xor_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      byte_ready_reg <= takes_bytes(state_next);
      mem_we_reg     <= (state_next == ST_WRITE);
      cpu_hold_reg   <= (state_next != ST_DONE);
      busy_reg       <= !(state_next == ST_IDLE || state_next == ST_DONE ||
                          state_next == ST_ERR);

      if (start_load) begin
        cnt_reg      <= '0;
        xor_reg      <= '0;
        done_reg     <= 1'b0;
        err_reg      <= 1'b0;
        err_code_reg <= 2'b00;
      end

      // The checksum byte itself is compared, not folded in.
      if (accept && state_reg != ST_CHK) xor_reg <= xor_reg ^ bus.byte_in;

      if (accept && state_reg == ST_LEN_HI) len_hi_reg <= bus.byte_in;
      if (accept && state_reg == ST_LEN_LO) len_reg    <= len_full[ADDR_W:0];
      if (accept && state_reg == ST_INS_HI) hi_reg     <= bus.byte_in;

      // Address and data are loaded together with mem_we so all three are
      // valid in the same WRITE cycle.
      if (accept && state_reg == ST_INS_LO) begin
        mem_addr_reg  <= cnt_reg[ADDR_W-1:0];
        mem_wdata_reg <= {hi_reg, bus.byte_in};
      end

      if (state_reg == ST_WRITE) cnt_reg <= cnt_reg + 1'b1;

      if (state_reg == ST_CHK && state_next == ST_DONE) done_reg <= 1'b1;

      if (state_reg != ST_ERR && state_next == ST_ERR) begin
        err_reg <= 1'b1;
        case (state_reg)
          ST_LEN_LO: err_code_reg <= 2'b01;
          ST_INS_HI: err_code_reg <= 2'b10;
          default:   err_code_reg <= 2'b11;
        endcase
      end
    end
  end

  assign bus.byte_ready = byte_ready_reg;
  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign cpu_hold       = cpu_hold_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign err            = err_reg;
  assign err_code       = err_code_reg;
  assign word_count     = cnt_reg;

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that writes the 16-bit instruction memory read by the processor's fetch/decode path. It receives a framed byte stream over a valid/ready handshake, packs bytes into instruction words, and rejects reserved opcodes before writing. It writes words to consecutive addresses from 0, verifies a trailing XOR checksum, and holds the CPU in reset until a load completes cleanly.

## Interface
- ADDR_W, 10: instruction memory address width; matches the 10-bit jump field D.
- DEPTH, 1024: maximum word count accepted; must be ≤ 2^ADDR_W.

- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR; ignored otherwise.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready.
- mem_we  out  1  instruction memory write strobe, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  16  instruction word {hi byte, lo byte}.
- cpu_hold  out  1  keeps CPU in reset.
- busy  out  1  load in progress.
- done  out  1  level; last load succeeded.
- err  out  1  level; last load failed.
- err_code  out  2  01 length > DEPTH, 10 reserved opcode, 11 checksum mismatch, 00 none.
- word_count  out  ADDR_W+1  words written in the current/last load.

## Operation
- Frame: LEN_HI, LEN_LO (16-bit N, big-endian), then N words as hi byte followed by lo byte, then CHK byte. CHK = XOR of every preceding frame byte, including the length bytes.
- Word formats checked on the hi byte:
  - ALU: [15:12] 0000–0111; fields R1 [11:8], R2 [7:4], Rd [3:0].
  - LI: [15:12] 1000; constant [11:4], Rd [3:0].
  - Jumps: [15:10] 111000–111101; D [9:0].
  - Reserved and rejected: [15:12] 1001–1101, and [15:10] 111110–111111.
- FSM states: IDLE, LEN_HI, LEN_LO, INS_HI, INS_LO, WRITE, CHK, DONE, ERR.
- State transitions:
  - IDLE/DONE/ERR + start → LEN_HI. On entry: clear index, word_count, running XOR, done, err and err_code.
  - LEN_HI → LEN_LO → (N > DEPTH ? ERR, code 01 : N == 0 ? CHK : INS_HI).
  - INS_HI: on accept, a reserved opcode → ERR with code 10, and nothing is written. Otherwise latch the hi byte → INS_LO.
  - INS_LO → WRITE.
  - WRITE: mem_we=1, mem_addr=index, mem_wdata={hi,lo}. Then index++, word_count++. Go to CHK if index+1 == N, else INS_HI.
  - CHK: on accept, byte == XOR → DONE; else ERR with code 11.
- byte_ready=1 only in LEN_HI, LEN_LO, INS_HI, INS_LO, CHK.
- The running XOR updates on every accepted byte except the CHK byte.
- cpu_hold=1 in every state except DONE.
- busy=1 in LEN_HI through CHK.
- Memory contents written before an error remain; the loader never erases them.

## Timing
- Reset (async, immediate) values:
  - State IDLE.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, busy=0, done=0, err=0, err_code=00, word_count=0.
- start is sampled on the clock edge; byte_ready rises the next cycle.
- Byte acceptance is one byte per cycle maximum. byte_valid may drop at any time; the FSM waits with no timeout.
- Each word costs 3 cycles minimum: hi accept, lo accept, WRITE. byte_ready=0 during WRITE.
- mem_we is registered, high exactly one cycle in WRITE. mem_addr and mem_wdata are stable that same cycle.
- done/err assert the cycle after the CHK byte is accepted, or after the erroring byte is accepted. cpu_hold falls in that same cycle on success.
- start asserted while busy is ignored.
- reset mid-load: abort immediately, mem_we deasserts asynchronously, and the loader returns to IDLE with cpu_hold=1.
- N == DEPTH is legal; the last write is at address DEPTH-1.
- word_count saturates by construction at DEPTH.

## Test plan
- Two-word load: 00 02 | 21 34 | 80 51 | CHK = 02^21^34^80^51 = C6. Required: writes [0]=2134, [1]=8051; done=1; cpu_hold=0; word_count=2.
- Reserved opcode: N=3, second word hi byte 0x9A. Required: only address 0 written; err=1, err_code=10; cpu_hold=1; word_count=1.
- Jump boundary: hi byte 0xF4 (111101) is accepted and written. Hi byte 0xF8 (111110) → err_code=10.
- Bad checksum: 00 01 | E0 05 | checksum 00 (expected E4). Required: word written; err_code=11; done=0.
- Length errors and boundaries:
  - 04 01 (N=1025, DEPTH=1024) → err_code=01 after the second byte, no writes.
  - 00 00 00 → done with zero writes.
- Robustness:
  - byte_valid toggling randomly still yields a correct load.
  - reset asserted during the second word: mem_we=0 immediately, state IDLE, cpu_hold=1.
  - A subsequent start plus a valid frame succeeds.
